fft_peak_rx: RTL and testbench

Receiving end of the FFT result stream. Consumes the framed per-bin output of the FFT wrapper: `startoftx` / `compoftx` framing, `top_toggle` data strobe, 4-bit signed `top_real` / `top_imag`. Computes an L1 magnitude per bin and reports the index and magnitude of the strongest bin once per frame. Sits between the FFT wrapper and the board outputs (LEDs / seven-seg), clocked by the slowed `dut_clk`.

---
 rtl/fft_peak_rx_if.sv | 25 ++
 rtl/fft_peak_rx.sv | 154 +++++++++++++++
 tb/tb_fft_peak_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_rx_if.sv
// FFT result stream plus peak report; master = FFT wrapper / board side, slave = fft_peak_rx.
interface fft_peak_rx_if #(
    parameter int BIN_W = 5
);
    logic             startoftx;
    logic             compoftx;
    logic             top_toggle;
    logic [3:0]       top_real;
    logic [3:0]       top_imag;
    logic [BIN_W-1:0] peak_bin;
    logic [4:0]       peak_mag;
    logic             frame_valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output startoftx, compoftx, top_toggle, top_real, top_imag,
        input  peak_bin, peak_mag, frame_valid, frame_err, busy
    );

    modport slave (
        input  startoftx, compoftx, top_toggle, top_real, top_imag,
        output peak_bin, peak_mag, frame_valid, frame_err, busy
    );
endinterface

// File: rtl/fft_peak_rx.sv
// Per-frame L1 peak search over toggle-strobed FFT bins; result 2 cycles after compoftx; no backpressure, one bin/cycle.
// Optional FFT_PEAK_RX_SKIP_DC_EN excludes bin 0 from the peak search (it is still counted).
module fft_peak_rx #(
    parameter int NBINS = 32,
    parameter int BIN_W = 5
) (
    input  logic         dut_clk,
    input  logic         reset,
    fft_peak_rx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    localparam logic [BIN_W:0] NBINS_C = (BIN_W+1)'(NBINS);
    localparam logic [BIN_W:0] CNT_ONE = {{BIN_W{1'b0}}, 1'b1};
`ifdef FFT_PEAK_RX_SKIP_DC_EN
    localparam bit SKIP_DC = 1'b1;
`else
    localparam bit SKIP_DC = 1'b0;
`endif

    function automatic logic [4:0] abs5(input logic [3:0] v);
        logic [4:0] x;
        x = {v[3], v};
        return x[4] ? (~x + 5'd1) : x;
    endfunction

    state_t           state_q, state_d;
    logic [BIN_W:0]   cnt_q, cnt_d;
    logic [4:0]       max_mag_q, max_mag_d;
    logic [BIN_W-1:0] max_bin_q, max_bin_d;
    logic             ovf_q, ovf_d;
    logic             tog_q, tog_d;
    logic             good_q, good_d;
    logic             bad_q, bad_d;
    logic [BIN_W-1:0] peak_bin_q, peak_bin_d;
    logic [4:0]       peak_mag_q, peak_mag_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    logic             tog_ev;
    logic [4:0]       bin_mag;

    assign tog_ev  = bus.top_toggle ^ tog_q;
    assign bin_mag = abs5(bus.top_real) + abs5(bus.top_imag);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        max_mag_d     = max_mag_q;
        max_bin_d     = max_bin_q;
        ovf_d         = ovf_q;
        tog_d         = bus.top_toggle;
        good_d        = 1'b0;
        bad_d         = 1'b0;
        peak_bin_d    = peak_bin_q;
        peak_mag_d    = peak_mag_q;
        frame_valid_d = good_q;
        frame_err_d   = bad_q;

        // The running max is still intact here: a new start cannot be accepted before this edge.
        if (good_q) begin
            peak_bin_d = max_bin_q;
            peak_mag_d = max_mag_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.startoftx) begin
                    state_d   = RECV;
                    cnt_d     = '0;
                    max_mag_d = '0;
                    max_bin_d = '0;
                    ovf_d     = 1'b0;
                end
            end
            RECV: begin
                if (bus.startoftx) begin
                    cnt_d     = '0;
                    max_mag_d = '0;
                    max_bin_d = '0;
                    ovf_d     = 1'b0;
                end else begin
                    if (tog_ev) begin
                        if (cnt_q < NBINS_C) begin
                            // Strict compare keeps the lowest index on ties.
                            if (!(SKIP_DC && cnt_q == '0) && bin_mag > max_mag_q) begin
                                max_mag_d = bin_mag;
                                max_bin_d = cnt_q[BIN_W-1:0];
                            end
                            cnt_d = cnt_q + CNT_ONE;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (bus.compoftx) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (cnt_q == NBINS_C && !ovf_q) begin
                    good_d = 1'b1;
                end else begin
                    bad_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RECV);
    end

    always_ff @(posedge dut_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            max_mag_q     <= '0;
            max_bin_q     <= '0;
            ovf_q         <= 1'b0;
            tog_q         <= 1'b0;
            good_q        <= 1'b0;
            bad_q         <= 1'b0;
            peak_bin_q    <= '0;
            peak_mag_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            max_mag_q     <= max_mag_d;
            max_bin_q     <= max_bin_d;
            ovf_q         <= ovf_d;
            tog_q         <= tog_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
            peak_bin_q    <= peak_bin_d;
            peak_mag_q    <= peak_mag_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.peak_bin    = peak_bin_q;
    assign bus.peak_mag    = peak_mag_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_fft_peak_rx.sv
// Directed bench for fft_peak_rx: hand-computed peaks, framing errors, restart and reset abort.
module tb_fft_peak_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] re_a [32];
    logic [3:0] im_a [32];

    fft_peak_rx_if #(.BIN_W(5)) bus();

    fft_peak_rx #(.NBINS(32), .BIN_W(5)) dut (
        .dut_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_bins();
        for (int i = 0; i < 32; i++) begin
            re_a[i] = 4'h0;
            im_a[i] = 4'h0;
        end
    endtask

    // Start, n toggles, close; merge puts compoftx on the last toggle's cycle.
    task automatic send_frame(input int n, input bit merge);
        bus.startoftx = 1'b1;
        tick();
        bus.startoftx = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            bus.top_toggle = ~bus.top_toggle;
            bus.top_real   = re_a[i % 32];
            bus.top_imag   = im_a[i % 32];
            if (merge && i == n - 1) bus.compoftx = 1'b1;
            tick();
        end
        if (!merge) begin
            bus.compoftx = 1'b1;
            tick();
        end
        bus.compoftx = 1'b0;
    endtask

    // Called just after the edge that sampled compoftx; pulse due two edges later.
    task automatic expect_result(input string tag, input bit v, input bit e,
                                 input int bin, input int mag, input bit start_in_done);
        chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
        chk({tag, "_no_early_pulse0"}, 32'({bus.frame_valid, bus.frame_err}), 32'd0);
        if (start_in_done) bus.startoftx = 1'b1;
        tick();
        bus.startoftx = 1'b0;
        chk({tag, "_no_early_pulse1"}, 32'({bus.frame_valid, bus.frame_err}), 32'd0);
        if (start_in_done) chk({tag, "_start_in_done_ignored"}, 32'(bus.busy), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(bus.frame_valid), 32'(v));
        chk({tag, "_err"}, 32'(bus.frame_err), 32'(e));
        chk({tag, "_bin"}, 32'(bus.peak_bin), 32'(bin));
        chk({tag, "_mag"}, 32'(bus.peak_mag), 32'(mag));
        tick();
        chk({tag, "_pulse_end"}, 32'({bus.frame_valid, bus.frame_err}), 32'd0);
    endtask

    initial begin
        bus.startoftx  = 1'b0;
        bus.compoftx   = 1'b0;
        bus.top_toggle = 1'b0;
        bus.top_real   = 4'h0;
        bus.top_imag   = 4'h0;
        clear_bins();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_peak_bin", 32'(bus.peak_bin), 32'd0);
        chk("rst_peak_mag", 32'(bus.peak_mag), 32'd0);
        chk("rst_pulses", 32'({bus.frame_valid, bus.frame_err}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // compoftx in IDLE and toggles in IDLE are ignored
        bus.compoftx   = 1'b1;
        bus.top_toggle = 1'b1;
        tick();
        bus.compoftx = 1'b0;
        tick();
        tick();
        tick();
        chk("idle_comp_no_pulse", 32'({bus.frame_valid, bus.frame_err}), 32'd0);
        chk("idle_comp_busy", 32'(bus.busy), 32'd0);

        // Single peak: bin 5 = (3,-2) -> mag 5
        re_a[5] = 4'd3; im_a[5] = 4'hE;
        send_frame(32, 1'b0);
        expect_result("t1", 1'b1, 1'b0, 5, 5, 1'b0);

        // Tie at -8,-8 on bins 7 and 12: lowest index, mag 16; start during DONE ignored
        clear_bins();
        re_a[7] = 4'h8;  im_a[7] = 4'h8;
        re_a[12] = 4'h8; im_a[12] = 4'h8;
        re_a[3] = 4'h7;  im_a[3] = 4'h1;
        send_frame(32, 1'b0);
        expect_result("t2", 1'b1, 1'b0, 7, 16, 1'b1);

        // Short and long frames are errors; previous peak held
        send_frame(31, 1'b0);
        expect_result("t3_short", 1'b0, 1'b1, 7, 16, 1'b0);
        send_frame(33, 1'b0);
        expect_result("t3_long", 1'b0, 1'b1, 7, 16, 1'b0);

        // Restart after 10 large bins; only the restarted frame counts
        clear_bins();
        re_a[20] = 4'd4; im_a[20] = 4'd4;
        bus.startoftx = 1'b1;
        tick();
        bus.startoftx = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.top_toggle = ~bus.top_toggle;
            bus.top_real   = 4'd7;
            bus.top_imag   = 4'd7;
            tick();
        end
        send_frame(32, 1'b1);
        expect_result("t4", 1'b1, 1'b0, 20, 8, 1'b0);

        // DC bin handling
        clear_bins();
        re_a[0] = 4'd7; im_a[0] = 4'd7;
        re_a[9] = 4'd1;
`ifdef FFT_PEAK_RX_SKIP_DC_EN
        send_frame(32, 1'b0);
        expect_result("t5_dc", 1'b1, 1'b0, 9, 1, 1'b0);
`else
        send_frame(32, 1'b0);
        expect_result("t5_dc", 1'b1, 1'b0, 0, 14, 1'b0);
`endif

        // All-zero frame reports bin 0, mag 0
        clear_bins();
        send_frame(32, 1'b0);
        expect_result("t6_zero", 1'b1, 1'b0, 0, 0, 1'b0);

        // Reset at toggle 16 aborts silently; following clean frame reports bin 3
        clear_bins();
        re_a[3] = 4'd2;
        re_a[10] = 4'd6;
        bus.startoftx = 1'b1;
        tick();
        bus.startoftx = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.top_toggle = ~bus.top_toggle;
            bus.top_real   = re_a[i];
            bus.top_imag   = im_a[i];
            tick();
        end
        rst = 1'b1;
        bus.compoftx = 1'b1;
        tick();
        rst = 1'b0;
        bus.compoftx = 1'b0;
        chk("t7_rst_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t7_no_pulse", 32'({bus.frame_valid, bus.frame_err}), 32'd0);
        end
        re_a[10] = 4'd0;
        send_frame(32, 1'b0);
        expect_result("t7", 1'b1, 1'b0, 3, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
